// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32 M-extension multi-cycle unit.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: unsigned shift-add multiply / restoring divide on
// operand magnitudes, with sign fix-up and result selection.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic [XLEN-1:0] o_result
);

  logic [2:0]        r_func3;
  logic              r_neg;      // product / quotient must be negated
  logic              r_neg_rem;  // remainder follows dividend sign
  logic [XLEN-1:0]   r_b;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_add;
  logic [XLEN+1:0]   w_shift;
  logic [XLEN+1:0]   w_diff;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  // Operand sign decode and magnitudes, plus one multiply/divide step.
  always_comb begin
    w_a_signed = (i_func3 == F3_MUL) || (i_func3 == F3_MULH) || (i_func3 == F3_MULHSU) ||
                 (i_func3 == F3_DIV) || (i_func3 == F3_REM);
    w_b_signed = (i_func3 == F3_MUL) || (i_func3 == F3_MULH) ||
                 (i_func3 == F3_DIV) || (i_func3 == F3_REM);
    w_sa    = w_a_signed & i_op_a[XLEN-1];
    w_sb    = w_b_signed & i_op_b[XLEN-1];
    w_abs_a = w_sa ? -i_op_a : i_op_a;
    w_abs_b = w_sb ? -i_op_b : i_op_b;
    w_add   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_b : '0)};
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_diff  = w_shift - {2'b00, r_b};
  end

  // Load magnitudes on start, then iterate once per step strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_func3   <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b       <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
    end else if (i_load) begin
      r_func3   <= i_func3;
      r_neg     <= w_sa ^ w_sb;
      r_neg_rem <= w_sa;
      r_b       <= w_abs_b;
      r_prod    <= {{XLEN{1'b0}}, w_abs_a};
      r_rem     <= '0;
      r_quo     <= w_abs_a;
    end else if (i_step) begin
      if (r_func3[2]) begin
        // Trial subtract; a borrow means restore the shifted remainder.
        if (!w_diff[XLEN+1]) begin
          r_rem <= w_diff[XLEN:0];
          r_quo <= {r_quo[XLEN-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[XLEN:0];
          r_quo <= {r_quo[XLEN-2:0], 1'b0};
        end
      end else begin
        r_prod <= {w_add, r_prod[XLEN-1:1]};
      end
    end
  end

  // Sign correction and output word selection.
  always_comb begin
    w_prod_fix = r_neg ? -r_prod : r_prod;
    w_quo_fix  = r_neg ? -r_quo : r_quo;
    w_rem_fix  = r_neg_rem ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    case (r_func3)
      F3_MUL:                      o_result = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             o_result = w_quo_fix;
      default:                     o_result = w_rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32 M-extension sequencer: control FSM, special-case divide handling,
// pipeline stall and registered result around muldiv_iter_core.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OP_A,
  input  logic [XLEN-1:0] OP_B,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  logic             w_load;
  logic             w_step;
  logic             w_wr_res;
  logic [XLEN-1:0]  w_res_val;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic [XLEN-1:0]  w_spec_res;
  logic [XLEN-1:0]  w_core_res;

  muldiv_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_clk    (CLK),
    .i_rst_n  (RESET_N),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_func3  (FUNC3),
    .i_op_a   (OP_A),
    .i_op_b   (OP_B),
    .o_result (w_core_res)
  );

  // Divide cases answered without iterating.
  always_comb begin
    w_div_zero = FUNC3[2] && (OP_B == '0);
    w_div_ovf  = ((FUNC3 == F3_DIV) || (FUNC3 == F3_REM)) && (OP_A == MIN_NEG) && (OP_B == '1);
    if (w_div_zero) w_spec_res = FUNC3[1] ? OP_A : '1;
    else            w_spec_res = FUNC3[1] ? '0 : OP_A;
  end

  // Next-state and datapath strobes; FLUSH returns to IDLE from any state.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_wr_res  = 1'b0;
    w_res_val = '0;
    case (r_state)
      S_IDLE: begin
        if (START && !FLUSH) begin
          w_load = 1'b1;
          if (w_div_zero || w_div_ovf) begin
            w_next    = S_DONE;
            w_wr_res  = 1'b1;
            w_res_val = w_spec_res;
          end else begin
            w_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (FLUSH) begin
          w_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(XLEN - 1)) w_next = S_FIX;
        end
      end
      S_FIX: begin
        if (FLUSH) begin
          w_next = S_IDLE;
        end else begin
          w_wr_res  = 1'b1;
          w_res_val = w_core_res;
          w_next    = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, iteration counter and registered status/result outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      if (w_wr_res) r_result <= w_res_val;
      if (w_load)      r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign STALL  = ((r_state == S_IDLE) && START && !FLUSH) || (r_state == S_CALC) || (r_state == S_FIX);
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign RESULT = r_result;

endmodule
